// File: rtl/xor_cipher_cfg_loader.sv
// Serial configuration initiator for the XOR cipher: shifts a 67-bit word into the
// cipher chain LSB first while capturing the displaced contents as a readback word.
module xor_cipher_cfg_loader #(
    parameter int CFG_WIDTH = 67,
    parameter int CNT_W     = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 read_only,
    input  logic                 k_mux_sel,
    input  logic                 a_mux_sel,
    input  logic                 d_en_sel,
    input  logic [31:0]          taps,
    input  logic [31:0]          seed,
    output logic                 busy,
    output logic                 done,
    output logic [CFG_WIDTH-1:0] readback,
    output logic                 cfg_en,
    output logic                 cfg_i,
    input  logic                 cfg_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CFG_WIDTH - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CFG_WIDTH-1:0] shreg_q, shreg_d;
    logic [CFG_WIDTH-1:0] cap_q, cap_d;
    logic [CFG_WIDTH-1:0] readback_q, readback_d;
    logic                 ro_q, ro_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 cfg_en_q, cfg_en_d;
    logic                 cfg_i_q, cfg_i_d;
    logic [CFG_WIDTH-1:0] word_s;

    assign word_s = {k_mux_sel, a_mux_sel, d_en_sel, taps, seed};

    // Next-state logic; cfg_i_q is pre-loaded one bit ahead so the serial data is registered.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        cap_d      = cap_q;
        readback_d = readback_q;
        ro_d       = ro_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cfg_en_d   = cfg_en_q;
        cfg_i_d    = cfg_i_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SHIFT;
                    cnt_d    = '0;
                    shreg_d  = {1'b0, word_s[CFG_WIDTH-1:1]};
                    cfg_i_d  = word_s[0];
                    ro_d     = read_only;
                    busy_d   = 1'b1;
                    cfg_en_d = 1'b1;
                end else begin
                    busy_d   = 1'b0;
                    cfg_en_d = 1'b0;
                end
            end
            SHIFT: begin
                cap_d   = {cfg_o, cap_q[CFG_WIDTH-1:1]};
                shreg_d = {1'b0, shreg_q[CFG_WIDTH-1:1]};
                cfg_i_d = shreg_q[0];
                if (cnt_q == LAST_CNT) begin
                    state_d    = IDLE;
                    busy_d     = 1'b0;
                    cfg_en_d   = 1'b0;
                    cfg_i_d    = 1'b0;
                    done_d     = 1'b1;
                    readback_d = {cfg_o, cap_q[CFG_WIDTH-1:1]};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                cfg_en_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            cap_q      <= '0;
            readback_q <= '0;
            ro_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_en_q   <= 1'b0;
            cfg_i_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            cap_q      <= cap_d;
            readback_q <= readback_d;
            ro_q       <= ro_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cfg_en_q   <= cfg_en_d;
            cfg_i_q    <= cfg_i_d;
        end
    end

    // Read mode loops the chain output straight back so the chain rotates onto itself.
    assign cfg_i    = (cfg_en_q && ro_q) ? cfg_o : cfg_i_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign cfg_en   = cfg_en_q;
    assign readback = readback_q;

endmodule

// File: tb/tb_xor_cipher_cfg_loader.sv
// Bench for xor_cipher_cfg_loader: a cipher chain model, a burst-level reference model
// checked every cycle, and directed scenarios with hand-computed expectations.
module tb_xor_cipher_cfg_loader;

    logic        clk = 1'b0;
    logic        rst, start, read_only, k_mux_sel, a_mux_sel, d_en_sel;
    logic [31:0] taps, seed;
    logic        busy, done, cfg_en, cfg_i, cfg_o;
    logic [66:0] readback;

    logic [66:0] chain;
    logic        load_chain;
    logic [66:0] load_val;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    localparam logic [66:0] W1  = {3'b101, 32'hDEADBEEF, 32'h12345678};
    localparam logic [66:0] W3  = {3'b010, 32'hCAFEF00D, 32'h0BADBEEF};
    localparam logic [66:0] WX  = {3'b111, 32'h11111111, 32'h22222222};
    localparam logic [66:0] W4  = {3'b011, 32'hA5A5A5A5, 32'h5A5A5A5A};
    localparam logic [66:0] W5  = {3'b100, 32'h01234567, 32'h89ABCDEF};
    localparam logic [66:0] W6  = {3'b110, 32'hFFFF0000, 32'h0000FFFF};
    localparam logic [66:0] W7  = {3'b001, 32'h13579BDF, 32'h2468ACE0};
    localparam logic [66:0] PRE = 67'h0_0000_0060_0000_0055;

    always #5 clk = ~clk;

    xor_cipher_cfg_loader dut (
        .clk(clk), .rst(rst), .start(start), .read_only(read_only),
        .k_mux_sel(k_mux_sel), .a_mux_sel(a_mux_sel), .d_en_sel(d_en_sel),
        .taps(taps), .seed(seed), .busy(busy), .done(done), .readback(readback),
        .cfg_en(cfg_en), .cfg_i(cfg_i), .cfg_o(cfg_o)
    );

    // Target configuration chain: shifts right, cfg_i enters at the top.
    always @(posedge clk) begin
        if (load_chain) chain <= load_val;
        else if (cfg_en) chain <= {cfg_i, chain[66:1]};
    end
    assign cfg_o = chain[0];

    // Burst-level model: remaining shift count, word, mode and the chain snapshot.
    int          rem = 0;
    logic [66:0] m_word = '0;
    logic [66:0] m_snap = '0;
    logic [66:0] m_rb = '0;
    logic        m_ro = 1'b0;
    logic        m_done = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            rem = 0; m_done = 1'b0; m_rb = '0;
        end else begin
            m_done = 1'b0;
            if (rem == 0) begin
                if (start) begin
                    rem    = 67;
                    m_word = {k_mux_sel, a_mux_sel, d_en_sel, taps, seed};
                    m_ro   = read_only;
                    m_snap = chain;
                end
            end else begin
                rem = rem - 1;
                if (rem == 0) begin
                    m_done = 1'b1;
                    m_rb   = m_snap;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [66:0] act, input logic [66:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {66'd0, busy}, {66'd0, rem > 0});
            check("cfg_en", {66'd0, cfg_en}, {66'd0, rem > 0});
            check("done", {66'd0, done}, {66'd0, m_done});
            check("readback", readback, m_rb);
            if (rem > 0)
                check("cfg_i", {66'd0, cfg_i}, {66'd0, m_ro ? chain[0] : m_word[67-rem]});
        end
    end

    task automatic set_word(input logic [66:0] w, input logic ro);
        {k_mux_sel, a_mux_sel, d_en_sel, taps, seed} = w;
        read_only = ro;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int en_cyc);
        en_cyc = 0;
        for (int i = 0; i < 200; i++) begin
            if (cfg_en) en_cyc++;
            if (done) return;
            @(negedge clk);
        end
        total++; bad++;
        $display("FAIL done_timeout: no done pulse within 200 cycles");
    endtask

    int n_en;
    int idle_en;

    initial begin
        rst = 1'b1; start = 1'b0; load_chain = 1'b1; load_val = '0;
        set_word('0, 1'b0);
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        rst = 1'b0; load_chain = 1'b0;
        @(negedge clk);
        check("rst_busy", {66'd0, busy}, 67'd0);
        check("rst_done", {66'd0, done}, 67'd0);
        check("rst_cfg_en", {66'd0, cfg_en}, 67'd0);
        check("rst_cfg_i", {66'd0, cfg_i}, 67'd0);
        check("rst_readback", readback, 67'd0);
        idle_en = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cfg_en) idle_en++;
        end
        check("idle_no_en", 67'(idle_en), 67'd0);

        // Write burst over a preloaded chain
        load_val = PRE; load_chain = 1'b1;
        @(negedge clk);
        load_chain = 1'b0;
        set_word(W1, 1'b0);
        pulse_start();
        set_word('0, 1'b0);
        wait_done(n_en);
        check("wr_en_cycles", 67'(n_en), 67'd67);
        check("wr_readback", readback, PRE);
        check("wr_chain", chain, W1);

        // Read mode: chain must come back unchanged
        @(negedge clk);
        set_word(WX, 1'b1);
        pulse_start();
        wait_done(n_en);
        check("rd_en_cycles", 67'(n_en), 67'd67);
        check("rd_readback_lo", {3'd0, readback[63:0]}, {3'd0, 64'hDEADBEEF12345678});
        check("rd_readback", readback, W1);
        check("rd_chain", chain, W1);

        // Busy-ignore: starts at N+10 and N+67
        @(negedge clk);
        set_word(W3, 1'b0);
        pulse_start();
        repeat (9) @(negedge clk);
        set_word(WX, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (56) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("bi_done", {66'd0, done}, 67'd1);
        check("bi_readback", readback, W1);
        check("bi_chain", chain, W3);
        repeat (5) @(negedge clk);
        check("bi_no_second", {66'd0, cfg_en}, 67'd0);
        check("bi_chain_hold", chain, W3);

        // Back-to-back: start in the done cycle
        set_word(W4, 1'b0);
        pulse_start();
        wait_done(n_en);
        check("b2b_first_rb", readback, W3);
        check("b2b_gap_low", {66'd0, cfg_en}, 67'd0);
        set_word(W5, 1'b0);
        pulse_start();
        check("b2b_gap_high", {66'd0, cfg_en}, 67'd1);
        wait_done(n_en);
        check("b2b_en_cycles", 67'(n_en), 67'd67);
        check("b2b_second_rb", readback, W4);
        check("b2b_chain", chain, W5);

        // Reset mid-burst, then a full rewrite
        @(negedge clk);
        set_word(W6, 1'b0);
        pulse_start();
        repeat (29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mr_cfg_en", {66'd0, cfg_en}, 67'd0);
        check("mr_busy", {66'd0, busy}, 67'd0);
        check("mr_readback", readback, 67'd0);
        idle_en = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done) idle_en++;
        end
        check("mr_no_done", 67'(idle_en), 67'd0);
        set_word(W7, 1'b0);
        pulse_start();
        wait_done(n_en);
        check("mr_en_cycles", 67'(n_en), 67'd67);
        check("mr_chain", chain, W7);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
